lcd_bus_decoder: RTL and testbench
==================================

Name: lcd_bus_decoder

Overview:
- Receiving end of the calculator's character-LCD write bus (lcd_e, lcd_rs, lcd_rw, lcd_data).
- Decodes HD44780-style instructions and data writes into a 2x16 shadow display buffer plus controller state.
- Used as an on-chip display mirror and as a bench checker for calculator LCD output, such as operand digits and sums.
- Synchronous to the same clock that drives the LCD bus; no CDC.

Parameters:
LINE_LEN, 16, visible characters per line; fixed 2 lines; buffer index = line*LINE_LEN + column
CLR_CHAR, 8'h20, fill value written by Clear Display and reset

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
lcd_e  input  1  LCD enable strobe; transfer executes on its falling edge
lcd_rs  input  1  0 = instruction, 1 = data
lcd_rw  input  1  0 = write, 1 = read (not supported)
lcd_data  input  8  LCD bus data
rd_addr  input  5  buffer read index 0..31
rd_char  output  8  buffer character at rd_addr, registered
busy  output  1  high while a multi-cycle Clear is in progress
char_wr_valid  output  1  one-cycle pulse per data write landing in the visible buffer
char_wr_pos  output  5  buffer index of that write
char_wr_data  output  8  character of that write
cursor_addr  output  7  current address counter (AC)
disp_on  output  1  Display On/Off D bit
cursor_on  output  1  Display On/Off C bit
blink_on  output  1  Display On/Off B bit
err_read  output  1  sticky: strobe seen with lcd_rw=1
err_overrun  output  1  sticky: strobe arrived while busy

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Input capture: e_d, rs_d, rw_d, data_d are registered every cycle.
  - Strobe = e_d & ~lcd_e.
  - The transfer uses rs_d/rw_d/data_d, i.e. values present while E was high.
- Reset:
  - All 32 cells = CLR_CHAR; AC = 0; id = 1; cg_mode = 0.
  - disp_on, cursor_on, blink_on = 0.
  - busy = 0; char_wr_valid = 0; rd_char = 0.
  - err_read, err_overrun = 0.
  - Reset mid-Clear aborts the Clear; the buffer is still reset to CLR_CHAR.
- FSM:
  - States: IDLE, CLEAR.
  - CLEAR lasts exactly 32 cycles, writing CLR_CHAR to index 0..31, one per cycle; busy = 1 throughout.
  - CLEAR returns to IDLE on the cycle after index 31 is written.
- Strobe while busy: ignored entirely; err_overrun set.
- Strobe with rw_d=1: ignored; err_read set.
- Instructions (rs_d=0), decoded by highest set bit:
  - 0x01 Clear: enter CLEAR; AC = 0; id = 1; cg_mode = 0.
  - 0x02/0x03 Return Home: AC = 0; cg_mode = 0.
  - 0x04-0x07 Entry Mode: id = data[1]; shift bit ignored.
  - 0x08-0x0F Display Control: disp_on = d[2], cursor_on = d[1], blink_on = d[0].
  - 0x10-0x1F Cursor/Display Shift:
    - If d[3]=0, AC steps +1 when d[2]=1, otherwise -1, using the wrap rules below.
    - Display shift (d[3]=1) is a no-op.
  - 0x20-0x3F Function Set: accepted, no effect.
  - 0x40-0x7F Set CGRAM: cg_mode = 1.
  - 0x80-0xFF Set DDRAM: AC = d[6:0]; cg_mode = 0.
- Data write (rs_d=1, rw_d=0):
  - If cg_mode: discard.
  - Otherwise, if AC is in 0x00..LINE_LEN-1 or 0x40..0x40+LINE_LEN-1, store at the mapped index and pulse char_wr_valid with that pos/data in the same cycle as the store.
  - In all non-cg cases, AC then steps by id.
- AC stepping and wrap:
  - Valid ranges are 0x00-0x27 and 0x40-0x67.
  - Increment: 0x27 → 0x40; 0x67 → 0x00.
  - Decrement: 0x00 → 0x67; 0x40 → 0x27.
  - AC loaded with an out-of-range value steps as a plain 7-bit count until it re-enters a valid range.
- Read port: rd_char = buffer[rd_addr] one cycle later. A same-cycle write is not forwarded; the old value is returned.

Optional Feature:
- Macro: LCD_DEC_ASCII_FILTER_EN.
- Defined: any data write with a byte < 0x20 or > 0x7E stores 0x3F ('?'), and char_wr_data reports 0x3F.
- Undefined: bytes are stored verbatim.

Test Plan:
- Reset:
  - Stimulus: rst, then read indices 0..31.
  - Required: every rd_char = 0x20; cursor_addr = 0; busy = 0.
- Operand digits:
  - Stimulus: instr 0x80; data 0x32, 0x33.
  - Required: index 0 = '2', index 1 = '3'; cursor_addr = 0x02; two char_wr_valid pulses at pos 0, 1.
- Line 2 and wrap:
  - Stimulus: instr 0xC0; data 0x34, 0x35, 0x36 ('456'); then instr 0xA7 and data 0x39.
  - Required: indices 16..18 = '456'; after the write at AC 0x27, cursor_addr = 0x40 with no char_wr_valid pulse (0x27 is off-screen).
- Clear and overrun:
  - Stimulus: instr 0x01; strobe data 0x41 at clear cycle 10.
  - Required: busy high for exactly 32 cycles; 'A' not stored; err_overrun = 1; all cells = 0x20.
- Decrement mode, CGRAM mode and read strobe:
  - Stimulus: instr 0x04, 0x80, data 0x58; then instr 0x40, data 0x59; then a strobe with lcd_rw=1.
  - Required: 'X' at index 0; cursor_addr = 0x67; 'Y' discarded; err_read = 1.
- Filter:
  - Stimulus: instr 0x85; data 0x07.
  - Required: index 5 = 0x3F with LCD_DEC_ASCII_FILTER_EN defined, 0x07 without.

Source files
------------

// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: receiving end of an HD44780-style character-LCD write bus.
// Mirrors the 2-line visible DDRAM into a shadow buffer and tracks controller
// state (address counter, entry mode, display control) for on-chip display
// mirroring and for checking calculator LCD output.
//
// Optional build macro: LCD_DEC_ASCII_FILTER_EN
//   defined   -> data bytes outside 0x20..0x7E are stored and reported as '?'
//   undefined -> data bytes are stored verbatim
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | accepting bus transfers
// CLEAR  | writing CLR_CHAR to cells 0..31, one per cycle; busy = 1
module lcd_bus_decoder #(
    parameter int          LINE_LEN = 16,
    parameter logic [7:0]  CLR_CHAR = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_e,
    input  logic        lcd_rs,
    input  logic        lcd_rw,
    input  logic [7:0]  lcd_data,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_char,
    output logic        busy,
    output logic        char_wr_valid,
    output logic [4:0]  char_wr_pos,
    output logic [7:0]  char_wr_data,
    output logic [6:0]  cursor_addr,
    output logic        disp_on,
    output logic        cursor_on,
    output logic        blink_on,
    output logic        err_read,
    output logic        err_overrun
);

    localparam int         NCELL = 2 * LINE_LEN;
    localparam logic [6:0] LINE2 = 7'h40;
    localparam logic [6:0] LLEN7 = 7'(LINE_LEN);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // Non-printable bytes become '?' only when the filter is built in.
    function automatic logic [7:0] filter_char(input logic [7:0] b);
`ifdef LCD_DEC_ASCII_FILTER_EN
        if ((b < 8'h20) || (b > 8'h7E)) begin
            return 8'h3F;
        end
        return b;
`else
        return b;
`endif
    endfunction

    // Address counter step with the two-line DDRAM wrap points; values outside
    // the valid ranges simply count until they fall back into one.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        if (inc) begin
            if (ac == 7'h27) return 7'h40;
            if (ac == 7'h67) return 7'h00;
            return ac + 7'd1;
        end
        if (ac == 7'h00) return 7'h67;
        if (ac == 7'h40) return 7'h27;
        return ac - 7'd1;
    endfunction

    logic        e_d, rs_d, rw_d;
    logic [7:0]  data_d;
    logic        strobe;
    logic        xfer_ok;
    logic        clear_cmd;

    state_t      state_q, state_n;
    logic [4:0]  clr_cnt, clr_cnt_n;
    logic        clr_we;
    logic [4:0]  clr_idx;

    logic [7:0]  buf_q [NCELL];

    logic [6:0]  ac_q, ac_n;
    logic        id_q, id_n;
    logic        cg_q, cg_n;
    logic        disp_n, cursor_n, blink_n;
    logic        ac_vis;
    logic [4:0]  ac_idx;
    logic        wr_en;
    logic [7:0]  wr_char;

    // Register the bus every cycle; the transfer acts on what was seen while E was high.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_d    <= 1'b0;
            rs_d   <= 1'b0;
            rw_d   <= 1'b0;
            data_d <= 8'h00;
        end else begin
            e_d    <= lcd_e;
            rs_d   <= lcd_rs;
            rw_d   <= lcd_rw;
            data_d <= lcd_data;
        end
    end

    assign strobe    = e_d & ~lcd_e;
    assign busy      = (state_q == S_CLEAR);
    assign xfer_ok   = strobe & ~busy & ~rw_d;
    assign clear_cmd = xfer_ok & ~rs_d & (data_d == 8'h01);

    // Clear sweep counts down; the cell index is the complement so cells fill 0..31.
    assign clr_idx = ~clr_cnt;

    // FSM state register and clear down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            clr_cnt <= 5'd0;
        end else begin
            state_q <= state_n;
            clr_cnt <= clr_cnt_n;
        end
    end

    // FSM next state: a Clear instruction starts a 32-cycle sweep.
    always_comb begin
        state_n   = state_q;
        clr_cnt_n = clr_cnt;
        clr_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear_cmd) begin
                    state_n   = S_CLEAR;
                    clr_cnt_n = 5'd31;
                end
            end
            S_CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt == 5'd0) begin
                    state_n = S_IDLE;
                end else begin
                    clr_cnt_n = clr_cnt - 5'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign ac_vis = (ac_q < LLEN7) || ((ac_q >= LINE2) && (ac_q < (LINE2 + LLEN7)));
    assign ac_idx = (ac_q < LINE2) ? 5'(ac_q) : 5'(ac_q - LINE2 + LLEN7);

    // Instruction / data decode for one accepted transfer.
    always_comb begin
        ac_n     = ac_q;
        id_n     = id_q;
        cg_n     = cg_q;
        disp_n   = disp_on;
        cursor_n = cursor_on;
        blink_n  = blink_on;
        wr_en    = 1'b0;
        wr_char  = filter_char(data_d);
        if (xfer_ok) begin
            if (!rs_d) begin
                casez (data_d)
                    8'b1???????: begin
                        ac_n = data_d[6:0];
                        cg_n = 1'b0;
                    end
                    8'b01??????: cg_n = 1'b1;
                    8'b001?????: ;
                    8'b0001????: begin
                        if (!data_d[3]) begin
                            ac_n = ac_step(ac_q, data_d[2]);
                        end
                    end
                    8'b00001???: begin
                        disp_n   = data_d[2];
                        cursor_n = data_d[1];
                        blink_n  = data_d[0];
                    end
                    8'b000001??: id_n = data_d[1];
                    8'b0000001?: begin
                        ac_n = 7'h00;
                        cg_n = 1'b0;
                    end
                    8'b00000001: begin
                        ac_n = 7'h00;
                        id_n = 1'b1;
                        cg_n = 1'b0;
                    end
                    default: ;
                endcase
            end else if (!cg_q) begin
                wr_en = ac_vis;
                ac_n  = ac_step(ac_q, id_q);
            end
        end
    end

    // Shadow buffer: reset fill, clear sweep, or a visible data write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCELL; i++) begin
                buf_q[i] <= CLR_CHAR;
            end
        end else if (clr_we) begin
            buf_q[clr_idx] <= CLR_CHAR;
        end else if (wr_en) begin
            buf_q[ac_idx] <= wr_char;
        end
    end

    // Controller state, write-event reporting, sticky errors and read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            ac_q          <= 7'h00;
            id_q          <= 1'b1;
            cg_q          <= 1'b0;
            disp_on       <= 1'b0;
            cursor_on     <= 1'b0;
            blink_on      <= 1'b0;
            char_wr_valid <= 1'b0;
            char_wr_pos   <= 5'd0;
            char_wr_data  <= 8'h00;
            err_read      <= 1'b0;
            err_overrun   <= 1'b0;
            rd_char       <= 8'h00;
        end else begin
            ac_q          <= ac_n;
            id_q          <= id_n;
            cg_q          <= cg_n;
            disp_on       <= disp_n;
            cursor_on     <= cursor_n;
            blink_on      <= blink_n;
            char_wr_valid <= wr_en;
            if (wr_en) begin
                char_wr_pos  <= ac_idx;
                char_wr_data <= wr_char;
            end
            err_read      <= err_read | (strobe & ~busy & rw_d);
            err_overrun   <= err_overrun | (strobe & busy);
            rd_char       <= buf_q[rd_addr];
        end
    end

    assign cursor_addr = ac_q;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Directed bench for lcd_bus_decoder: bus stimulus pushes expected write events
// into a queue that a separate monitor pops whenever char_wr_valid is seen.
module tb_lcd_bus_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        lcd_e, lcd_rs, lcd_rw;
    logic [7:0]  lcd_data;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_char;
    logic        busy;
    logic        char_wr_valid;
    logic [4:0]  char_wr_pos;
    logic [7:0]  char_wr_data;
    logic [6:0]  cursor_addr;
    logic        disp_on, cursor_on, blink_on;
    logic        err_read, err_overrun;

    int vectors = 0;
    int miscompares = 0;

    logic [12:0] exp_q [$];

    lcd_bus_decoder dut (
        .clk           (clk),
        .rst           (rst),
        .lcd_e         (lcd_e),
        .lcd_rs        (lcd_rs),
        .lcd_rw        (lcd_rw),
        .lcd_data      (lcd_data),
        .rd_addr       (rd_addr),
        .rd_char       (rd_char),
        .busy          (busy),
        .char_wr_valid (char_wr_valid),
        .char_wr_pos   (char_wr_pos),
        .char_wr_data  (char_wr_data),
        .cursor_addr   (cursor_addr),
        .disp_on       (disp_on),
        .cursor_on     (cursor_on),
        .blink_on      (blink_on),
        .err_read      (err_read),
        .err_overrun   (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] pos, input logic [7:0] ch);
        exp_q.push_back({pos, ch});
    endtask

    // One complete bus cycle; effects are visible when this returns.
    task automatic bus_xfer(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        lcd_rs   = rs;
        lcd_rw   = rw;
        lcd_data = d;
        lcd_e    = 1'b1;
        @(negedge clk);
        lcd_e    = 1'b0;
        @(negedge clk);
    endtask

    task automatic instr(input logic [7:0] d);
        bus_xfer(1'b0, 1'b0, d);
    endtask

    task automatic data_wr(input logic [7:0] d);
        bus_xfer(1'b1, 1'b0, d);
    endtask

    task automatic check_cell(input int idx, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = 5'(idx);
        @(negedge clk);
        check($sformatf("cell[%0d]", idx), rd_char, exp);
    endtask

    // Monitor: every write pulse must match the oldest outstanding expectation.
    initial begin
        logic [12:0] e;
        forever begin
            @(negedge clk);
            if (!rst && char_wr_valid) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL wr_unexpected: got pos %0d data 0x%02h, expected no write",
                             char_wr_pos, char_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({char_wr_pos, char_wr_data} !== e) begin
                        miscompares++;
                        $display("FAIL wr_event: got pos %0d data 0x%02h, expected pos %0d data 0x%02h",
                                 char_wr_pos, char_wr_data, e[12:8], e[7:0]);
                    end
                end
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int          bcnt;
        logic [7:0]  filt_exp;

        rst      = 1'b1;
        lcd_e    = 1'b0;
        lcd_rs   = 1'b0;
        lcd_rw   = 1'b0;
        lcd_data = 8'h00;
        rd_addr  = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_rd_char", rd_char, 8'h00);
        rst = 1'b0;

        // Reset state
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_cursor", {1'b0, cursor_addr}, 8'h00);
        check("rst_disp", {5'd0, disp_on, cursor_on, blink_on}, 8'h00);
        check("rst_err", {6'd0, err_read, err_overrun}, 8'h00);
        for (int i = 0; i < 32; i++) check_cell(i, 8'h20);

        // Operand digits
        instr(8'h80);
        expect_wr(5'd0, 8'h32); data_wr(8'h32);
        expect_wr(5'd1, 8'h33); data_wr(8'h33);
        check("digits_cursor", {1'b0, cursor_addr}, 8'h02);
        check_cell(0, 8'h32);
        check_cell(1, 8'h33);

        // Line 2 and wrap off the end of line 1's DDRAM
        instr(8'hC0);
        expect_wr(5'd16, 8'h34); data_wr(8'h34);
        expect_wr(5'd17, 8'h35); data_wr(8'h35);
        expect_wr(5'd18, 8'h36); data_wr(8'h36);
        check("line2_cursor", {1'b0, cursor_addr}, 8'h43);
        instr(8'hA7);
        check("ac_27", {1'b0, cursor_addr}, 8'h27);
        data_wr(8'h39);
        check("wrap_cursor", {1'b0, cursor_addr}, 8'h40);
        check_cell(16, 8'h34);
        check_cell(17, 8'h35);
        check_cell(18, 8'h36);

        // Display control
        instr(8'h0D);
        check("disp_ctrl", {5'd0, disp_on, cursor_on, blink_on}, 8'h05);

        // Clear with an overrunning data strobe mid-sweep
        instr(8'h01);
        bcnt = busy ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 7) begin
                lcd_rs   = 1'b1;
                lcd_rw   = 1'b0;
                lcd_data = 8'h41;
                lcd_e    = 1'b1;
            end else if (i == 8) begin
                lcd_e = 1'b0;
            end
            if (busy) bcnt++;
            else if (i > 8) break;
        end
        check("clear_busy_cycles", 8'(bcnt), 8'd32);
        check("overrun", {7'd0, err_overrun}, 8'h01);
        check("clear_cursor", {1'b0, cursor_addr}, 8'h00);
        for (int i = 0; i < 32; i++) check_cell(i, 8'h20);

        // Decrement mode, CGRAM discard and read strobe
        instr(8'h04);
        instr(8'h80);
        expect_wr(5'd0, 8'h58); data_wr(8'h58);
        check("dec_cursor", {1'b0, cursor_addr}, 8'h67);
        instr(8'h40);
        data_wr(8'h59);
        check("cg_cursor", {1'b0, cursor_addr}, 8'h67);
        check("err_read_pre", {7'd0, err_read}, 8'h00);
        bus_xfer(1'b0, 1'b1, 8'h80);
        check("err_read", {7'd0, err_read}, 8'h01);
        check("rd_no_effect", {1'b0, cursor_addr}, 8'h67);
        check_cell(0, 8'h58);

        // Filter (id still decrements)
`ifdef LCD_DEC_ASCII_FILTER_EN
        filt_exp = 8'h3F;
`else
        filt_exp = 8'h07;
`endif
        instr(8'h85);
        expect_wr(5'd5, filt_exp); data_wr(8'h07);
        check("filt_cursor", {1'b0, cursor_addr}, 8'h04);
        check_cell(5, filt_exp);

        // Cursor shift, home, and increment wrap 0x67 -> 0x00
        instr(8'h14);
        check("shift_right", {1'b0, cursor_addr}, 8'h05);
        instr(8'h10);
        check("shift_left", {1'b0, cursor_addr}, 8'h04);
        instr(8'h18);
        check("disp_shift_noop", {1'b0, cursor_addr}, 8'h04);
        instr(8'h02);
        check("home", {1'b0, cursor_addr}, 8'h00);
        instr(8'h06);
        instr(8'hE7);
        data_wr(8'h21);
        check("wrap_67", {1'b0, cursor_addr}, 8'h00);
        instr(8'h8F);
        expect_wr(5'd15, 8'h4B); data_wr(8'h4B);
        check("inc_cursor", {1'b0, cursor_addr}, 8'h10);
        check_cell(15, 8'h4B);

        // Reset in the middle of a Clear
        instr(8'h01);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midclr_busy", {7'd0, busy}, 8'h00);
        check("midclr_err", {6'd0, err_read, err_overrun}, 8'h00);
        check_cell(31, 8'h20);
        check_cell(15, 8'h20);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
